fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 64-bit LEGv8 pipelined processor. Sits directly upstream of the IF/ID
//   consumer. Owns the PC and drives the combinational instruction memory address.
//   Registers {instruction, PC, valid} into the IF/ID boundary.
//   Applies branch redirect, stall and flush, and halts fetch on a HLT encoding.
// PARAMETERS
//   N           64            datapath / PC width
//   RESET_PC    64'h0         PC loaded on reset
//   HALT_OPCODE 32'hD4400000  instruction word that stops fetch (HLT #0)
//   IMEM_WORDS  256           instruction memory depth in 32-bit words (out-of-range check)
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   reset        in   1   synchronous, active-low: reset==0 at a rising edge resets the block
//   IM_addr      out  N   = PC register, combinational; imem indexes IM_addr[9:2]
//   IM_readData  in   32  instruction at IM_addr, valid in the same cycle (combinational imem)
//   PCSrc        in   1   branch taken (resolved in MEM); redirect to PCBranch
//   PCBranch     in   N   branch target address
//   stall        in   1   load-use hazard; hold PC and IF/ID
//   flush        in   1   squash the instruction being fetched this cycle
//   IF_ID_instr  out  32  registered instruction (0 when bubble)
//   IF_ID_pc     out  N   registered PC of IF_ID_instr
//   IF_ID_valid  out  1   IF_ID holds a real instruction
//   halted       out  1   FSM in HALT
//   fetch_count  out  32  valid instructions delivered into IF/ID, saturating
//   pc_oob       out  1   sticky: fetched from PC >= 4*IMEM_WORDS or PC[1:0]!=0
// BEHAVIOUR
//   Reset (reset==0 at edge), overrides all inputs:
//     state=BOOT, PC=RESET_PC, IF_ID_instr=0, IF_ID_pc=0, IF_ID_valid=0,
//     halted=0, fetch_count=0, pc_oob=0.
//   FSM states: BOOT, RUN, HALT.
//     BOOT: lasts exactly 1 cycle. PC holds, IF_ID stays a bubble, inputs ignored.
//       Next state is RUN.
//     RUN, per edge, in priority order:
//       1. PCSrc=1 (wins over stall and flush): PC<=PCBranch; IF_ID<=bubble (instr=0, valid=0).
//       2. flush=1: IF_ID<=bubble; PC holds.
//       3. stall=1: PC, IF_ID and fetch_count hold.
//       4. Otherwise: IF_ID<={IM_readData, PC, valid=1}; PC<=PC+4, mod 2^N (wraps silently);
//          fetch_count++.
//       If case 4 loads IM_readData==HALT_OPCODE:
//         - the HLT word itself enters IF_ID as valid;
//         - PC stays at the HLT address (no +4);
//         - next state is HALT.
//     HALT: halted=1; PC frozen; IF_ID<=bubble every cycle; stall and flush are ignored.
//       PCSrc=1 (an older branch squashes the speculative HLT):
//         PC<=PCBranch; halted=0; next state is RUN.
//       Otherwise HALT is left only via reset.
//   Bubble definition: instr=0, valid=0, IF_ID_pc=0.
//   fetch_count: +1 only on a case-4 load; saturates at 32'hFFFFFFFF (no wrap).
//   pc_oob: set on the edge where a case-4 load occurs with an out-of-range or misaligned PC.
//     The fetch still proceeds. Cleared only by reset.
//   halted and IF_ID_* are registered outputs. IM_addr is the only combinational output.
// TESTING
//   1. Reset low 2 cycles, imem = 8 ADDs, then reset high.
//      -> BOOT 1 cycle with IF_ID_valid=0; IF_ID_pc = 0,4,8,... on consecutive cycles;
//         fetch_count=8 after 8 loads.
//   2. stall=1 for 3 cycles at PC=0x10.
//      -> IM_addr=0x10 and IF_ID unchanged for 3 cycles; fetch_count frozen;
//         resumes with IF_ID_pc=0x10.
//   3. PCSrc=1 and stall=1 together, PCBranch=0x40.
//      -> next edge PC=0x40, IF_ID_valid=0; the following edge IF_ID_pc=0x40, valid=1.
//   4. HALT_OPCODE at 0x20.
//      -> IF_ID_instr=32'hD4400000 valid at pc 0x20; then halted=1, IM_addr stays 0x20,
//         bubbles. Then PCSrc=1 with PCBranch=0x8 -> halted=0, fetch resumes at 0x8.
//   5. PCBranch=0x402 (misaligned and >= 4*256).
//      -> pc_oob=1 after the fetch and stays 1 through later in-range fetches
//         until a reset pulse.
//   6. Reset driven low mid-stall while in HALT with fetch_count=5.
//      -> all outputs return to reset values at that edge; BOOT follows.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the combinational imem address and registers
// {instruction, PC, valid} into IF/ID with branch redirect, stall, flush and HLT handling.
//
// state | meaning
// BOOT  | one-cycle settle after reset, PC held, IF/ID bubble
// RUN   | normal fetch with redirect/flush/stall priority
// HALT  | HLT fetched; PC frozen, bubbles until branch redirect or reset
module fetch_stage #(
  parameter int          N           = 64,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [31:0] HALT_OPCODE = 32'hD4400000,
  parameter int          IMEM_WORDS  = 256
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] IM_addr,
  input  logic [31:0]  IM_readData,
  input  logic         PCSrc,
  input  logic [N-1:0] PCBranch,
  input  logic         stall,
  input  logic         flush,
  output logic [31:0]  IF_ID_instr,
  output logic [N-1:0] IF_ID_pc,
  output logic         IF_ID_valid,
  output logic         halted,
  output logic [31:0]  fetch_count,
  output logic         pc_oob
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [N-1:0] OOB_LIMIT = N'(4 * IMEM_WORDS);

  logic [1:0]   state;
  logic [N-1:0] pc;
  logic         pc_bad;

  assign IM_addr = pc;
  assign pc_bad  = (pc >= OOB_LIMIT) || (pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC[N-1:0];
      IF_ID_instr <= '0;
      IF_ID_pc    <= '0;
      IF_ID_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
      pc_oob      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          IF_ID_instr <= '0;
          IF_ID_pc    <= '0;
          IF_ID_valid <= 1'b0;
        end
        RUN: begin
          if (PCSrc) begin
            pc          <= PCBranch;
            IF_ID_instr <= '0;
            IF_ID_pc    <= '0;
            IF_ID_valid <= 1'b0;
          end else if (flush) begin
            IF_ID_instr <= '0;
            IF_ID_pc    <= '0;
            IF_ID_valid <= 1'b0;
          end else if (!stall) begin
            IF_ID_instr <= IM_readData;
            IF_ID_pc    <= pc;
            IF_ID_valid <= 1'b1;
            if (fetch_count != 32'hFFFF_FFFF)
              fetch_count <= fetch_count + 32'd1;
            if (pc_bad)
              pc_oob <= 1'b1;
            // The HLT word is delivered, but PC parks on it so a redirect can squash it.
            if (IM_readData == HALT_OPCODE) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc + N'(4);
            end
          end
        end
        HALT: begin
          IF_ID_instr <= '0;
          IF_ID_pc    <= '0;
          IF_ID_valid <= 1'b0;
          if (PCSrc) begin
            pc     <= PCBranch;
            halted <= 1'b0;
            state  <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
